// File: rtl/tx_pingpong_scheduler.sv
// Ping-pong transmit sequencer: requests chunks, steers loads into the
// idle buffer, shifts the active one, swaps at chunk ends.
module tx_pingpong_scheduler #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] size,
  input  logic [CNT_W-1:0] burst,
  input  logic             bit_strobe,
  input  logic             data_valid,
  output logic             ready_data,
  output logic             load_buf0,
  output logic             load_buf1,
  output logic             shift_buf0,
  output logic             shift_buf1,
  output logic             sel_buf,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    STALL,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

  state_t           state;
  logic [CNT_W-1:0] sz;
  logic [CNT_W-1:0] bl;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] req_cnt;
  logic [CNT_W-1:0] sent_cnt;
  logic             full0;
  logic             full1;

  logic             accept;
  logic             tgt;
  logic             shift_any;
  logic             chunk_end;
  logic             last_chunk;
  logic             inact_full;
  logic             inact_fill;
  logic             more_req;
  logic [CNT_W-1:0] req_inc;
  logic [CNT_W-1:0] sz_in;

  assign accept     = ready_data & data_valid;
  // PRIME always fills buf0; afterwards loads go to the idle buffer
  assign tgt        = (state == PRIME) ? 1'b0 : ~sel_buf;
  assign load_buf0  = accept & ~tgt;
  assign load_buf1  = accept & tgt;

  assign shift_any  = bit_strobe & (state == RUN);
  assign shift_buf0 = shift_any & ~sel_buf;
  assign shift_buf1 = shift_any & sel_buf;

  assign chunk_end  = shift_any & (bit_cnt == sz - ONE);
  assign last_chunk = (sent_cnt + ONE) == bl;
  assign inact_full = sel_buf ? full0 : full1;
  assign inact_fill = inact_full | accept;
  assign req_inc    = req_cnt + {{(CNT_W-1){1'b0}}, accept};
  assign more_req   = req_inc < bl;

  assign sz_in = (size == '0 || size > FULL) ? FULL : size;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sz         <= '0;
      bl         <= '0;
      bit_cnt    <= '0;
      req_cnt    <= '0;
      sent_cnt   <= '0;
      full0      <= 1'b0;
      full1      <= 1'b0;
      ready_data <= 1'b0;
      sel_buf    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      done  <= 1'b0;
      full0 <= (full0 & ~(chunk_end & ~sel_buf)) | load_buf0;
      full1 <= (full1 & ~(chunk_end & sel_buf)) | load_buf1;
      if (shift_any)
        bit_cnt <= chunk_end ? '0 : bit_cnt + ONE;
      if (accept)
        req_cnt <= req_inc;
      if (chunk_end)
        sent_cnt <= sent_cnt + ONE;

      case (state)
        IDLE: begin
          if (start) begin
            sz       <= sz_in;
            bl       <= burst;
            underrun <= 1'b0;
            sel_buf  <= 1'b0;
            bit_cnt  <= '0;
            req_cnt  <= '0;
            sent_cnt <= '0;
            full0    <= 1'b0;
            full1    <= 1'b0;
            if (burst == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= PRIME;
              busy       <= 1'b1;
              ready_data <= 1'b1;
            end
          end
        end

        PRIME: begin
          if (accept) begin
            state      <= RUN;
            ready_data <= more_req;
          end
        end

        RUN: begin
          if (chunk_end) begin
            if (last_chunk) begin
              state      <= DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              ready_data <= 1'b0;
            end else if (inact_fill) begin
              // new idle buffer is the one just drained
              sel_buf    <= ~sel_buf;
              ready_data <= more_req;
            end else begin
              state      <= STALL;
              underrun   <= 1'b1;
              ready_data <= 1'b1;
            end
          end else begin
            ready_data <= more_req & ~inact_fill;
          end
        end

        STALL: begin
          if (accept) begin
            state      <= RUN;
            sel_buf    <= ~sel_buf;
            ready_data <= more_req;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_pingpong_scheduler.sv
// Scoreboard bench for tx_pingpong_scheduler: expected load/shift
// buffer ids are queued per burst and popped by a negedge monitor.
module tb_tx_pingpong_scheduler;

  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] size = '0;
  logic [CW-1:0] burst = '0;
  logic          bit_strobe = 1'b0;
  logic          data_valid = 1'b0;
  logic          ready_data;
  logic          load_buf0;
  logic          load_buf1;
  logic          shift_buf0;
  logic          shift_buf1;
  logic          sel_buf;
  logic          busy;
  logic          done;
  logic          underrun;

  tx_pingpong_scheduler #(.DATA_W(32), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .size       (size),
    .burst      (burst),
    .bit_strobe (bit_strobe),
    .data_valid (data_valid),
    .ready_data (ready_data),
    .load_buf0  (load_buf0),
    .load_buf1  (load_buf1),
    .shift_buf0 (shift_buf0),
    .shift_buf1 (shift_buf1),
    .sel_buf    (sel_buf),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_load[$];
  int   exp_shift[$];
  int   done_cnt = 0;
  bit   rd_seen = 1'b0;
  bit   sup_en = 1'b0;
  int   str_per = 0;
  int   scnt = 0;
  logic ready_q = 1'b0;

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // monitor
  always @(negedge clk) begin
    ready_q <= ready_data;
    if (ready_data) rd_seen = 1'b1;
    if (done) done_cnt++;
    if (load_buf0 || load_buf1) begin
      if (exp_load.size() == 0) unexpected("load");
      else check("load buffer", int'(load_buf1), exp_load.pop_front());
    end
    if (shift_buf0 || shift_buf1) begin
      if (exp_shift.size() == 0) unexpected("shift");
      else check("shift buffer", int'(shift_buf1), exp_shift.pop_front());
    end
  end

  // supplier: answers one cycle after seeing ready_data
  initial begin
    forever begin
      @(posedge clk);
      #1;
      data_valid = sup_en & ready_q;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      scnt++;
      bit_strobe = (str_per != 0) && (scnt % str_per == 0);
    end
  end

  task automatic push_shift(int b, int n);
    for (int i = 0; i < n; i++) exp_shift.push_back(b);
  endtask

  task automatic pulse_start(int s, int b);
    @(posedge clk);
    #1;
    size  = CW'(s);
    burst = CW'(b);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(string name, int budget);
    int i = 0;
    while ((exp_load.size() != 0 || exp_shift.size() != 0 || busy)
           && i < budget) begin
      @(posedge clk);
      i++;
    end
    n_vec++;
    if (i >= budget) begin
      n_err++;
      $display("FAIL %s timeout: loads left %0d, shifts left %0d",
               name, exp_load.size(), exp_shift.size());
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_shifts_left(string name, int left, int budget);
    int i = 0;
    while (exp_shift.size() > left && i < budget) begin
      @(posedge clk);
      i++;
    end
    n_vec++;
    if (i >= budget) begin
      n_err++;
      $display("FAIL %s timeout: shifts left %0d, wanted %0d",
               name, exp_shift.size(), left);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs",
          int'({ready_data, load_buf0, load_buf1, shift_buf0, shift_buf1,
                sel_buf, busy, done, underrun}), 0);
    rst_n = 1'b1;

    // size 8, burst 3, prompt supplier
    done_cnt = 0;
    exp_load = {0, 1, 0};
    push_shift(0, 8);
    push_shift(1, 8);
    push_shift(0, 8);
    sup_en  = 1'b1;
    str_per = 4;
    pulse_start(8, 3);
    wait_drain("t1", 400);
    check("t1 done count", done_cnt, 1);
    check("t1 underrun", int'(underrun), 0);

    // size 4, burst 2, supplier silent after first chunk
    done_cnt = 0;
    exp_load = {0, 1};
    push_shift(0, 4);
    push_shift(1, 4);
    str_per = 3;
    pulse_start(4, 2);
    for (int i = 0; i < 50 && exp_load.size() > 1; i++) @(posedge clk);
    sup_en = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t2 underrun in stall", int'(underrun), 1);
    check("t2 shifts left in stall", exp_shift.size(), 4);
    check("t2 ready in stall", int'(ready_data), 1);
    sup_en = 1'b1;
    wait_drain("t2", 300);
    check("t2 done count", done_cnt, 1);
    check("t2 underrun sticky", int'(underrun), 1);

    // size 0 means 32 bits, burst 1
    done_cnt = 0;
    exp_load = {0};
    push_shift(0, 32);
    str_per = 2;
    pulse_start(0, 1);
    wait_drain("t3", 300);
    check("t3 done count", done_cnt, 1);
    check("t3 underrun cleared", int'(underrun), 0);

    // empty burst
    done_cnt = 0;
    rd_seen  = 1'b0;
    pulse_start(5, 0);
    wait_drain("t4", 20);
    check("t4 done count", done_cnt, 1);
    check("t4 ready seen", int'(rd_seen), 0);

    // restart mid-burst is ignored
    done_cnt = 0;
    exp_load = {0, 1};
    push_shift(0, 8);
    push_shift(1, 8);
    str_per = 3;
    pulse_start(8, 2);
    wait_shifts_left("t5 mid", 11, 100);
    pulse_start(4, 5);
    wait_drain("t5", 300);
    check("t5 done count", done_cnt, 1);

    // reset after 5 shifts aborts without done
    done_cnt = 0;
    exp_load = {0, 1};
    push_shift(0, 5);
    pulse_start(8, 2);
    wait_shifts_left("t6 pre", 0, 100);
    rst_n = 1'b0;
    #1;
    check("t6 outputs in reset",
          int'({ready_data, load_buf0, load_buf1, shift_buf0, shift_buf1,
                sel_buf, busy, done, underrun}), 0);
    check("t6 loads before reset", exp_load.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t6 no done", done_cnt, 0);
    exp_load = {0, 1};
    push_shift(0, 8);
    push_shift(1, 8);
    pulse_start(8, 2);
    wait_drain("t6 post", 300);
    check("t6 done count", done_cnt, 1);
    check("t6 underrun", int'(underrun), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
